// File: rtl/kb_pkg.sv
// Shared constants and FSM encoding for the keyboard bus controller.
package kb_pkg;

  localparam logic [1:0] KB_ADDR_STATUS = 2'd0;
  localparam logic [1:0] KB_ADDR_DATA   = 2'd1;
  localparam logic [1:0] KB_ADDR_CTRL   = 2'd2;

  localparam int unsigned ST_BIT_KB_STATUS = 0;
  localparam int unsigned ST_BIT_BUF_FULL  = 1;
  localparam int unsigned ST_BIT_FULL_SEEN = 2;
  localparam int unsigned ST_BIT_IRQ_EN    = 3;

  localparam int unsigned CTRL_BIT_CLEAR    = 0;
  localparam int unsigned CTRL_BIT_IRQ_EN   = 1;
  localparam int unsigned CTRL_BIT_CLR_FULL = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_WAIT,
    ST_RESP,
    ST_CLEAR
  } kb_state_t;

endpackage

// File: rtl/kb_delay_counter.sv
// 4-bit loadable down-counter used to time both the pop wait and the clear pulse.
module kb_delay_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [3:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  // Asserted when the decrement taken this cycle brings the count to zero.
  assign o_zero = (r_count <= 4'd1);

endmodule

// File: rtl/kb_bus_controller.sv
// Memory-mapped STATUS/DATA/CONTROL slave between the CPU bus and the keyboard buffer.
module kb_bus_controller
  import kb_pkg::*;
#(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned READ_LAT     = 1,
  parameter int unsigned CLEAR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [1:0]        bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic              bus_ack,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              bus_err,
  output logic              irq,
  input  logic              KB_status,
  input  logic [6:0]        KB_data,
  input  logic              buf_full,
  output logic              KB_read_en,
  output logic              KB_clear
);

  kb_state_t         r_state;
  kb_state_t         w_next;
  logic              r_irq_en;
  logic              r_full_seen;
  logic              r_irq;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;

  logic              w_accept;
  logic              w_illegal;
  logic              w_ctrl_wr;
  logic [DATA_W-1:0] w_req_rdata;
  logic              w_load;
  logic [3:0]        w_load_val;
  logic              w_dec;
  logic              w_cnt_zero;
  logic              w_unused_wdata;

  assign w_unused_wdata = ^bus_wdata[DATA_W-1:3];

  assign w_accept  = (r_state == ST_IDLE) && bus_req;
  assign w_ctrl_wr = bus_we && (bus_addr == KB_ADDR_CTRL);
  assign w_illegal = (bus_addr == 2'd3) || (bus_we && (bus_addr != KB_ADDR_CTRL));
  assign irq       = r_irq;

  always_comb begin
    w_req_rdata = '0;
    if (!bus_we) begin
      case (bus_addr)
        KB_ADDR_STATUS: begin
          w_req_rdata[ST_BIT_KB_STATUS] = KB_status;
          w_req_rdata[ST_BIT_BUF_FULL]  = buf_full;
          w_req_rdata[ST_BIT_FULL_SEEN] = r_full_seen;
          w_req_rdata[ST_BIT_IRQ_EN]    = r_irq_en;
        end
        KB_ADDR_CTRL: w_req_rdata[CTRL_BIT_IRQ_EN] = r_irq_en;
        default:      w_req_rdata = '0;
      endcase
    end
  end

  kb_delay_counter u_delay (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    w_dec      = 1'b0;
    KB_read_en = 1'b0;
    KB_clear   = 1'b0;
    bus_ack    = 1'b0;
    bus_err    = 1'b0;
    bus_rdata  = '0;
    case (r_state)
      ST_IDLE: begin
        if (bus_req) begin
          if (w_illegal) begin
            w_next = ST_RESP;
          end else if (w_ctrl_wr && bus_wdata[CTRL_BIT_CLEAR]) begin
            w_next     = ST_CLEAR;
            w_load     = 1'b1;
            w_load_val = 4'(CLEAR_CYCLES);
          end else if (!bus_we && (bus_addr == KB_ADDR_DATA) && KB_status) begin
            w_next = ST_POP;
          end else begin
            w_next = ST_RESP;
          end
        end
      end
      ST_POP: begin
        KB_read_en = 1'b1;
        w_load     = 1'b1;
        w_load_val = 4'(READ_LAT);
        w_next     = ST_WAIT;
      end
      ST_WAIT: begin
        w_dec = 1'b1;
        if (w_cnt_zero) w_next = ST_RESP;
      end
      ST_CLEAR: begin
        KB_clear = 1'b1;
        w_dec    = 1'b1;
        if (w_cnt_zero) w_next = ST_RESP;
      end
      ST_RESP: begin
        bus_ack   = 1'b1;
        bus_err   = r_err;
        bus_rdata = r_rdata;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_en    <= 1'b0;
      r_full_seen <= 1'b0;
      r_irq       <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_irq <= r_irq_en & KB_status;
      if (w_accept && w_ctrl_wr) r_irq_en <= bus_wdata[CTRL_BIT_IRQ_EN];
      // A full buffer seen in the same cycle as a clear request keeps the flag set.
      if (buf_full) begin
        r_full_seen <= 1'b1;
      end else if (w_accept && w_ctrl_wr && bus_wdata[CTRL_BIT_CLR_FULL]) begin
        r_full_seen <= 1'b0;
      end
      if (w_accept) begin
        r_rdata <= w_req_rdata;
        r_err   <= w_illegal;
      end else if ((r_state == ST_WAIT) && w_cnt_zero) begin
        r_rdata <= DATA_W'({1'b1, KB_data});
      end
    end
  end

endmodule

// File: doc/kb_bus_controller.md
Name: kb_bus_controller

Overview:
- Memory-mapped slave that lets the Y86 core reach the keyboard path (keyboard_interface_top / keyboard_buf) through three registers: STATUS, DATA and CONTROL.
- Sequences buffer pops (KB_read_en) and buffer clears (KB_clear), captures KB_data and returns it over a single-outstanding req/ack bus handshake.
- Generates a level interrupt when data is waiting.
- Sits between the CPU memory-decode logic and keyboard_interface_top.

Parameters:
- DATA_W, 64, bus data width in bits; must be >= 8.
- READ_LAT, 1, cycles from the KB_read_en pulse until KB_data is valid; legal range 1..15.
- CLEAR_CYCLES, 2, cycles KB_clear is held high per clear command; legal range 1..15.

Ports:
- clk  in  1  master clock.
- reset  in  1  synchronous, active-high reset.
- bus_req  in  1  one-cycle request strobe; sampled only in IDLE.
- bus_we  in  1  1 = write, 0 = read; qualified by bus_req.
- bus_addr  in  2  register select: 0 STATUS, 1 DATA, 2 CONTROL, 3 reserved.
- bus_wdata  in  DATA_W  write data.
- bus_ack  out  1  one-cycle completion pulse.
- bus_rdata  out  DATA_W  read data; valid only while bus_ack=1, otherwise 0.
- bus_err  out  1  pulses with bus_ack on an illegal access.
- irq  out  1  level interrupt.
- KB_status  in  1  buffer non-empty.
- KB_data  in  7  ASCII code at the head of the buffer.
- buf_full  in  1  buffer full.
- KB_read_en  out  1  one-cycle pop strobe.
- KB_clear  out  1  buffer clear.

Behaviour:
- Reset:
  - Synchronous and dominant. State returns to IDLE immediately, even mid-pop or mid-clear.
  - bus_ack, bus_err, bus_rdata, irq, KB_read_en and KB_clear are all 0.
  - irq_en=0, full_seen=0, counters=0.
- Registers:
  - STATUS (read): bit0 KB_status, bit1 buf_full, bit2 full_seen, bit3 irq_en; all other bits 0.
  - DATA (read): bit7 = valid, bits6:0 = ASCII code; all other bits 0.
  - CONTROL (write): bit0 clear buffer, bit1 new irq_en value (always loaded), bit2 clear full_seen.
  - CONTROL read returns {irq_en at bit1}, all other bits 0.
- full_seen: sticky. Set on any cycle with buf_full=1; cleared by a CONTROL write with bit2=1. If set and clear occur in the same cycle, set wins.
- irq = irq_en & KB_status, registered (one cycle of lag).
- FSM states: IDLE, POP, WAIT, RESP, CLEAR.
- IDLE, when bus_req=1:
  - STATUS read, CONTROL read, or CONTROL write with bit0=0: go to RESP (ack the next cycle, 1-cycle latency). Read data is sampled on the request cycle.
  - DATA read with KB_status=1: go to POP.
  - DATA read with KB_status=0: go to RESP with rdata=0 (valid=0); no pop.
  - CONTROL write with bit0=1: go to CLEAR, with irq_en and full_seen updated on the request cycle.
  - Write to STATUS or DATA, or any access to addr 3: go to RESP with bus_err=1, rdata=0, no side effect.
- POP: KB_read_en=1 for exactly one cycle, load the counter with READ_LAT, go to WAIT.
- WAIT: decrement the counter. When it reaches 0, capture KB_data into a register and go to RESP.
  - Total DATA-pop latency from req to ack is READ_LAT+2 cycles.
- CLEAR: KB_clear=1 for CLEAR_CYCLES cycles, then go to RESP. Latency from req to ack is CLEAR_CYCLES+1.
- RESP: bus_ack=1 for one cycle, drive the response data, return to IDLE. Back-to-back requests are accepted on the cycle after ack.
- bus_req outside IDLE is ignored: not queued, no ack. The master must wait for ack before issuing again.
- KB_read_en and KB_clear are never high simultaneously, and never high outside POP/CLEAR.

Decomposition:
- Shared package kb_pkg holds:
  - address constants KB_ADDR_STATUS=0, KB_ADDR_DATA=1, KB_ADDR_CTRL=2;
  - STATUS and CONTROL bit-index constants;
  - the FSM state encoding.
- One natural sub-module: kb_delay_counter, a 4-bit loadable down-counter with a zero flag. It is shared between the WAIT and CLEAR states.
- Everything else stays flat.

Test Plan:
- Reset, then STATUS read with KB_status=0, buf_full=0 -> bus_ack on cycle 1 after req, rdata=0, bus_err=0.
- KB_status=1, KB_data=7'h41, DATA read (READ_LAT=1) -> KB_read_en pulses on cycle 1 only, ack on cycle 3, rdata=64'h00C1.
- DATA read with KB_status=0 -> ack on cycle 1, rdata=0, KB_read_en never asserted.
- CONTROL write 3'b011 (CLEAR_CYCLES=2) -> KB_clear high for cycles 1-2, ack on cycle 3, irq_en=1; then KB_status=1 -> irq=1 one cycle later.
- Pulse buf_full=1 for one cycle -> STATUS bit2=1 persists; CONTROL write 3'b100 -> bit2 reads 0.
- reset asserted during WAIT -> next cycle all outputs 0, no ack; write to addr 3 -> ack with bus_err=1; bus_req during POP -> ignored.
